// File: rtl/wei_buf.sv
// Ping-pong weight buffer: the loader fills one bank while the cache arbiter
// random-reads the other; a release pulse hands the read bank back for refill.
module wei_buf #(
  parameter int DATA_WIDTH     = 8,
  parameter int WEI_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      TOPWBF_CfgVld,
  output logic                      WBFTOP_CfgRdy,
  input  logic                      TOPWBF_DatVld,
  input  logic [DATA_WIDTH-1:0]     TOPWBF_Dat,
  input  logic                      TOPWBF_DatLast,
  output logic                      WBFTOP_DatRdy,
  input  logic                      TOPWBF_Rel,
  input  logic                      WCAWBF_AdrVld,
  input  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr,
  output logic                      WBFWCA_AdrRdy,
  output logic                      WBFWCA_DatVld,
  output logic [DATA_WIDTH-1:0]     WBFWCA_Dat,
  input  logic                      WCAWBF_DatRdy
);

  localparam int DEPTH = 2 ** WEI_ADDR_WIDTH;
  localparam logic [WEI_ADDR_WIDTH-1:0] ADDR_MAX = '1;

  logic [1:0]                bank_full;
  logic [1:0]                full_nxt;
  logic                      wr_bank;
  logic                      rd_bank;
  logic [WEI_ADDR_WIDTH-1:0] wr_cnt;
  logic [WEI_ADDR_WIDTH:0]   len [2];
  logic [DATA_WIDTH-1:0]     mem [2][DEPTH];

  logic                      vld_p1;
  logic [DATA_WIDTH-1:0]     dat_p1;

  logic                      flush_fire;
  logic                      wr_fire;
  logic                      close_fire;
  logic                      rel_fire;
  logic                      adr_fire;
  logic                      in_range;
  logic [DATA_WIDTH-1:0]     rd_word;

  // Addresses at or beyond the filled length read back as zero.
  function automatic logic [DATA_WIDTH-1:0] clip_rd(input logic hit,
                                                    input logic [DATA_WIDTH-1:0] word);
    return hit ? word : '0;
  endfunction

  assign WBFTOP_CfgRdy = !vld_p1;
  assign WBFTOP_DatRdy = !bank_full[wr_bank];
  assign WBFWCA_AdrRdy = bank_full[rd_bank] & (!vld_p1 | WCAWBF_DatRdy);
  assign WBFWCA_DatVld = vld_p1;
  assign WBFWCA_Dat    = dat_p1;

  // A flush swallows every other same-cycle event.
  assign flush_fire = TOPWBF_CfgVld & WBFTOP_CfgRdy;
  assign wr_fire    = TOPWBF_DatVld & WBFTOP_DatRdy & !flush_fire;
  assign close_fire = wr_fire & (TOPWBF_DatLast | (wr_cnt == ADDR_MAX));
  assign rel_fire   = TOPWBF_Rel & bank_full[rd_bank] & !flush_fire;
  assign adr_fire   = WCAWBF_AdrVld & WBFWCA_AdrRdy & !flush_fire;

  assign in_range = {1'b0, WCAWBF_Adr} < len[rd_bank];
  assign rd_word  = mem[rd_bank][WCAWBF_Adr];

  // Close is applied after release so it wins if both ever hit the same bank.
  always_comb begin
    full_nxt = bank_full;
    if (rel_fire)
      full_nxt[rd_bank] = 1'b0;
    if (close_fire)
      full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      len[0]    <= '0;
      len[1]    <= '0;
    end else if (flush_fire) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      len[0]    <= '0;
      len[1]    <= '0;
    end else begin
      bank_full <= full_nxt;
      if (close_fire) begin
        len[wr_bank] <= {1'b0, wr_cnt} + 1'b1;
        wr_bank      <= ~wr_bank;
        wr_cnt       <= '0;
      end else if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (rel_fire)
        rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_bank][wr_cnt] <= TOPWBF_Dat;
  end

  // Stage p1: registered read data, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      dat_p1 <= '0;
    end else if (adr_fire) begin
      vld_p1 <= 1'b1;
      dat_p1 <= clip_rd(in_range, rd_word);
    end else if (vld_p1 & WCAWBF_DatRdy) begin
      vld_p1 <= 1'b0;
      dat_p1 <= '0;
    end
  end

endmodule

// File: tb/tb_wei_buf.sv
// Directed and randomised checks of the ping-pong weight buffer.
module tb_wei_buf;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       TOPWBF_CfgVld;
  logic       WBFTOP_CfgRdy;
  logic       TOPWBF_DatVld;
  logic [7:0] TOPWBF_Dat;
  logic       TOPWBF_DatLast;
  logic       WBFTOP_DatRdy;
  logic       TOPWBF_Rel;
  logic       WCAWBF_AdrVld;
  logic [7:0] WCAWBF_Adr;
  logic       WBFWCA_AdrRdy;
  logic       WBFWCA_DatVld;
  logic [7:0] WBFWCA_Dat;
  logic       WCAWBF_DatRdy;

  int n_cmp = 0;
  int n_err = 0;

  wei_buf #(.DATA_WIDTH(8), .WEI_ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .TOPWBF_CfgVld(TOPWBF_CfgVld), .WBFTOP_CfgRdy(WBFTOP_CfgRdy),
    .TOPWBF_DatVld(TOPWBF_DatVld), .TOPWBF_Dat(TOPWBF_Dat),
    .TOPWBF_DatLast(TOPWBF_DatLast), .WBFTOP_DatRdy(WBFTOP_DatRdy),
    .TOPWBF_Rel(TOPWBF_Rel),
    .WCAWBF_AdrVld(WCAWBF_AdrVld), .WCAWBF_Adr(WCAWBF_Adr),
    .WBFWCA_AdrRdy(WBFWCA_AdrRdy), .WBFWCA_DatVld(WBFWCA_DatVld),
    .WBFWCA_Dat(WBFWCA_Dat), .WCAWBF_DatRdy(WCAWBF_DatRdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n bytes (base+i, or i^0x5A when xr is set) with no gaps.
  task automatic fill(input int n, input logic [7:0] base, input bit last, input bit xr);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = i[7:0];
      TOPWBF_DatVld  = 1'b1;
      TOPWBF_Dat     = xr ? (b ^ 8'h5A) : (base + b);
      TOPWBF_DatLast = last && (i == n - 1);
      tick();
    end
    TOPWBF_DatVld  = 1'b0;
    TOPWBF_DatLast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    TOPWBF_CfgVld = 0; TOPWBF_DatVld = 0; TOPWBF_Dat = 0; TOPWBF_DatLast = 0;
    TOPWBF_Rel = 0; WCAWBF_AdrVld = 0; WCAWBF_Adr = 0; WCAWBF_DatRdy = 0;
    tick(); tick();
    n_cmp++; if (WBFTOP_DatRdy !== 1'b1) begin n_err++; $display("FAIL rst_datrdy got=%b exp=1", WBFTOP_DatRdy); end
    n_cmp++; if (WBFWCA_AdrRdy !== 1'b0) begin n_err++; $display("FAIL rst_adrrdy got=%b exp=0", WBFWCA_AdrRdy); end
    n_cmp++; if (WBFTOP_CfgRdy !== 1'b1) begin n_err++; $display("FAIL rst_cfgrdy got=%b exp=1", WBFTOP_CfgRdy); end
    n_cmp++; if ({WBFWCA_DatVld, WBFWCA_Dat} !== 9'h000) begin n_err++; $display("FAIL rst_out got=%b/%h exp=0/00", WBFWCA_DatVld, WBFWCA_Dat); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    fill(4, 8'h11, 1, 0);
    n_cmp++; if (WBFWCA_AdrRdy !== 1'b1) begin n_err++; $display("FAIL wr_bank0_full got=%b exp=1", WBFWCA_AdrRdy); end
    n_cmp++; if (WBFTOP_DatRdy !== 1'b1) begin n_err++; $display("FAIL wr_datrdy got=%b exp=1", WBFTOP_DatRdy); end
    WCAWBF_AdrVld = 1; WCAWBF_Adr = 8'd2; WCAWBF_DatRdy = 0;
    tick();
    WCAWBF_AdrVld = 0;
    n_cmp++; if ({WBFWCA_DatVld, WBFWCA_Dat} !== {1'b1, 8'h13}) begin n_err++; $display("FAIL rd_adr2 got=%b/%h exp=1/13", WBFWCA_DatVld, WBFWCA_Dat); end
    WCAWBF_DatRdy = 1;
    tick();
    n_cmp++; if (WBFWCA_DatVld !== 1'b0) begin n_err++; $display("FAIL rd_consume got=%b exp=0", WBFWCA_DatVld); end
  endtask

  task automatic test_oob_stream();
    WCAWBF_AdrVld = 1; WCAWBF_Adr = 8'd7; WCAWBF_DatRdy = 1;
    tick();
    n_cmp++; if ({WBFWCA_DatVld, WBFWCA_Dat} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL rd_oob got=%b/%h exp=1/00", WBFWCA_DatVld, WBFWCA_Dat); end
    for (int i = 0; i < 4; i++) begin
      WCAWBF_Adr = i[7:0];
      tick();
      n_cmp++; if ({WBFWCA_DatVld, WBFWCA_Dat} !== {1'b1, 8'h11 + i[7:0]}) begin
        n_err++; $display("FAIL rd_stream%0d got=%b/%h exp=1/%h", i, WBFWCA_DatVld, WBFWCA_Dat, 8'h11 + i[7:0]);
      end
    end
    WCAWBF_AdrVld = 0;
    tick();
    n_cmp++; if (WBFWCA_DatVld !== 1'b0) begin n_err++; $display("FAIL rd_stream_end got=%b exp=0", WBFWCA_DatVld); end
  endtask

  task automatic test_backpressure();
    WCAWBF_AdrVld = 1; WCAWBF_Adr = 8'd1; WCAWBF_DatRdy = 0;
    tick();
    WCAWBF_Adr = 8'd3;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({WBFWCA_AdrRdy, WBFWCA_Dat} !== {1'b0, 8'h12}) begin
        n_err++; $display("FAIL bp_hold%0d got=%b/%h exp=0/12", i, WBFWCA_AdrRdy, WBFWCA_Dat);
      end
      n_cmp++; if (WBFTOP_CfgRdy !== 1'b0) begin n_err++; $display("FAIL bp_cfgrdy got=%b exp=0", WBFTOP_CfgRdy); end
      tick();
    end
    WCAWBF_DatRdy = 1;
    #1;
    n_cmp++; if (WBFWCA_AdrRdy !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b exp=1", WBFWCA_AdrRdy); end
    tick();
    WCAWBF_AdrVld = 0;
    n_cmp++; if (WBFWCA_Dat !== 8'h14) begin n_err++; $display("FAIL bp_next got=%h exp=14", WBFWCA_Dat); end
    tick();
  endtask

  task automatic test_autoclose_full();
    fill(256, 8'h00, 0, 1);
    n_cmp++; if (WBFTOP_DatRdy !== 1'b0) begin n_err++; $display("FAIL both_full_datrdy got=%b exp=0", WBFTOP_DatRdy); end
    TOPWBF_Rel = 1;
    tick();
    TOPWBF_Rel = 0;
    n_cmp++; if (WBFTOP_DatRdy !== 1'b1) begin n_err++; $display("FAIL rel_datrdy got=%b exp=1", WBFTOP_DatRdy); end
    WCAWBF_AdrVld = 1; WCAWBF_Adr = 8'd255; WCAWBF_DatRdy = 1;
    tick();
    n_cmp++; if (WBFWCA_Dat !== 8'hA5) begin n_err++; $display("FAIL auto_len256 got=%h exp=a5", WBFWCA_Dat); end
    WCAWBF_Adr = 8'd0;
    tick();
    WCAWBF_AdrVld = 0;
    n_cmp++; if (WBFWCA_Dat !== 8'h5A) begin n_err++; $display("FAIL bank1_adr0 got=%h exp=5a", WBFWCA_Dat); end
    tick();
  endtask

  task automatic test_rel_same_cycle();
    fill(3, 8'h21, 1, 0);
    TOPWBF_Rel = 1; WCAWBF_AdrVld = 1; WCAWBF_Adr = 8'd3; WCAWBF_DatRdy = 1;
    tick();
    TOPWBF_Rel = 0;
    n_cmp++; if ({WBFWCA_DatVld, WBFWCA_Dat} !== {1'b1, 8'h59}) begin n_err++; $display("FAIL rel_old_bank got=%b/%h exp=1/59", WBFWCA_DatVld, WBFWCA_Dat); end
    WCAWBF_Adr = 8'd1;
    tick();
    n_cmp++; if (WBFWCA_Dat !== 8'h22) begin n_err++; $display("FAIL rel_new_bank got=%h exp=22", WBFWCA_Dat); end
    WCAWBF_Adr = 8'd5;
    tick();
    WCAWBF_AdrVld = 0;
    n_cmp++; if (WBFWCA_Dat !== 8'h00) begin n_err++; $display("FAIL rel_new_oob got=%h exp=00", WBFWCA_Dat); end
    tick();
  endtask

  task automatic test_flush();
    fill(2, 8'h31, 1, 0);
    n_cmp++; if (WBFTOP_DatRdy !== 1'b0) begin n_err++; $display("FAIL pre_flush_full got=%b exp=0", WBFTOP_DatRdy); end
    TOPWBF_CfgVld = 1;
    tick();
    TOPWBF_CfgVld = 0;
    n_cmp++; if ({WBFWCA_AdrRdy, WBFTOP_DatRdy} !== 2'b01) begin n_err++; $display("FAIL flush_state got=%b%b exp=01", WBFWCA_AdrRdy, WBFTOP_DatRdy); end
    fill(1, 8'h77, 1, 0);
    WCAWBF_AdrVld = 1; WCAWBF_Adr = 8'd0; WCAWBF_DatRdy = 1;
    tick();
    n_cmp++; if (WBFWCA_Dat !== 8'h77) begin n_err++; $display("FAIL flush_wr_adr0 got=%h exp=77", WBFWCA_Dat); end
    WCAWBF_Adr = 8'd1;
    tick();
    WCAWBF_AdrVld = 0;
    n_cmp++; if (WBFWCA_Dat !== 8'h00) begin n_err++; $display("FAIL flush_len1 got=%h exp=00", WBFWCA_Dat); end
    tick();
  endtask

  task automatic test_reset_mid();
    WCAWBF_AdrVld = 1; WCAWBF_Adr = 8'd0; WCAWBF_DatRdy = 0;
    tick();
    WCAWBF_AdrVld = 0;
    n_cmp++; if (WBFWCA_DatVld !== 1'b1) begin n_err++; $display("FAIL mid_pending got=%b exp=1", WBFWCA_DatVld); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({WBFWCA_DatVld, WBFWCA_Dat, WBFWCA_AdrRdy} !== 10'h000) begin
      n_err++; $display("FAIL mid_async got=%b/%h/%b exp=0/00/0", WBFWCA_DatVld, WBFWCA_Dat, WBFWCA_AdrRdy);
    end
    tick();
    rst_n = 1'b1;
    WCAWBF_DatRdy = 1;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] ref_mem [256];
    logic [7:0] exp_q [$];
    logic [7:0] e;
    int n, i, guard;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) ref_mem[k] = 8'($urandom);
      i = 0; guard = 0;
      while (i < n && guard < 200) begin
        TOPWBF_DatVld  = 1'($urandom);
        TOPWBF_Dat     = ref_mem[i];
        TOPWBF_DatLast = (i == n - 1);
        #1;
        if (TOPWBF_DatVld && WBFTOP_DatRdy) i++;
        tick();
        guard++;
      end
      TOPWBF_DatVld = 0; TOPWBF_DatLast = 0;
      n_cmp++; if (i != n) begin n_err++; $display("FAIL rnd_fill%0d got=%0d exp=%0d", r, i, n); end
      for (int c = 0; c < 45; c++) begin
        WCAWBF_AdrVld = (c < 40) ? 1'($urandom) : 1'b0;
        WCAWBF_Adr    = 8'($urandom_range(0, n + 3));
        WCAWBF_DatRdy = (c < 40) ? 1'($urandom) : 1'b1;
        #1;
        if (WBFWCA_DatVld && WCAWBF_DatRdy) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          n_cmp++; if (WBFWCA_Dat !== e) begin n_err++; $display("FAIL rnd_data%0d got=%h exp=%h", r, WBFWCA_Dat, e); end
        end
        if (WCAWBF_AdrVld && WBFWCA_AdrRdy)
          exp_q.push_back((int'(WCAWBF_Adr) < n) ? ref_mem[WCAWBF_Adr] : 8'h00);
        tick();
      end
      WCAWBF_AdrVld = 0;
      n_cmp++; if (exp_q.size() != 0 || WBFWCA_DatVld !== 1'b0) begin
        n_err++; $display("FAIL rnd_drain%0d got=%0d/%b exp=0/0", r, exp_q.size(), WBFWCA_DatVld);
        exp_q.delete();
      end
      TOPWBF_Rel = 1;
      tick();
      TOPWBF_Rel = 0;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_oob_stream();
    test_backpressure();
    test_autoclose_full();
    test_rel_same_cycle();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
